zbuf_sequencer: RTL and testbench

Controller for the 4-channel, 128-deep whitened-sample buffer (Z1..Z4) of the FastICA processor. It loads one batch of whitened samples from the whitening stage into the buffer, then replays the whole batch to the fixed-point iteration unit once per iteration pass. It stops after a programmed pass count or on the iteration unit's convergence flag. It owns the buffer's write enable, read enable and address, and it reports pass and batch completion.

---
 rtl/fica_pkg.sv | 17 +
 rtl/wrap_counter.sv | 44 ++++
 rtl/zbuf_sequencer.sv | 158 +++++++++++++++
 tb/tb_zbuf_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fica_pkg.sv
// Shared FastICA definitions: whitened-sample buffer geometry, pass counter
// width and the Z-buffer sequencer state encoding.
package fica_pkg;

    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned PASS_W = 8;

    typedef enum logic [2:0] {
        ZS_IDLE = 3'd0,
        ZS_LOAD = 3'd1,
        ZS_PASS = 3'd2,
        ZS_GAP  = 3'd3,
        ZS_DONE = 3'd4
    } zseq_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Buffer address counter with enable and synchronous clear.
// DEPTH is a power of two, so the counter wraps to 0 after DEPTH-1 on its own.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   en        advance the address by one
//   clr       synchronous clear to 0 (dominates en)
//   cnt       current address
//   tc        terminal count, cnt == DEPTH-1
module wrap_counter #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/zbuf_sequencer.sv
// Z1..Z4 whitened-sample buffer controller: loads one batch from the
// whitening stage, then replays it to the iteration unit once per pass until
// the programmed pass count is reached or convergence is reported.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, num_passes     batch request (IDLE only) and pass count to latch
//   in_valid / in_ready   load handshake with the whitening stage
//   stream_en             iteration unit can take a sample; low pauses replay
//   converged             convergence level from the iteration unit
//   mem_we, mem_re        buffer write / read strobes (all four lanes)
//   mem_addr              buffer address
//   samp_valid, samp_last read data valid / last-address qualifier (latency 1)
//   pass_done, pass_idx   end-of-pass pulse, completed pass count
//   busy, done            not-IDLE level, end-of-batch pulse
module zbuf_sequencer
    import fica_pkg::*;
#(
    parameter int unsigned DEPTH  = fica_pkg::DEPTH,
    parameter int unsigned ADDR_W = fica_pkg::ADDR_W,
    parameter int unsigned PASS_W = fica_pkg::PASS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stream_en,
    input  logic              converged,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              samp_valid,
    output logic              samp_last,
    output logic              pass_done,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CMP_W = PASS_W + 1;

    zseq_state_t       state_q, state_d;
    logic [PASS_W-1:0] npass_q, npass_d;
    logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
    logic              conv_q, conv_d;
    logic              samp_valid_q, samp_valid_d;
    logic              samp_last_q, samp_last_d;

    logic              cnt_en;
    logic              cnt_clr;
    logic              cnt_tc;
    logic              last_pass;

    // One counter serves both the load and the replay address streams.
    wrap_counter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .cnt (mem_addr),
        .tc  (cnt_tc)
    );

    // Widened compare so pass_idx+1 cannot wrap at the counter maximum.
    assign last_pass = ((CMP_W'(pass_idx_q) + CMP_W'(1)) == CMP_W'(npass_q));

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        npass_d    = npass_q;
        pass_idx_d = pass_idx_q;
        conv_d     = conv_q;
        cnt_clr    = 1'b0;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        pass_done  = 1'b0;
        done       = 1'b0;
        busy       = (state_q != ZS_IDLE);

        case (state_q)
            ZS_IDLE: begin
                if (start) begin
                    npass_d    = num_passes;
                    pass_idx_d = '0;
                    conv_d     = 1'b0;
                    cnt_clr    = 1'b1;
                    state_d    = ZS_LOAD;
                end
            end
            ZS_LOAD: begin
                in_ready = 1'b1;
                mem_we   = in_valid;
                if (in_valid && cnt_tc) begin
                    state_d = (npass_q == '0) ? ZS_DONE : ZS_PASS;
                end
            end
            ZS_PASS: begin
                mem_re = stream_en;
                if (converged) begin
                    conv_d = 1'b1;
                end
                if (stream_en && cnt_tc) begin
                    state_d = ZS_GAP;
                end
            end
            ZS_GAP: begin
                pass_done = 1'b1;
                if (converged) begin
                    conv_d = 1'b1;
                end
                if (pass_idx_q != '1) begin
                    pass_idx_d = pass_idx_q + PASS_W'(1);
                end
                // Convergence seen in this very cycle also ends the batch.
                state_d = (last_pass || conv_q || converged) ? ZS_DONE : ZS_PASS;
            end
            ZS_DONE: begin
                done    = 1'b1;
                state_d = ZS_IDLE;
            end
            default: begin
                state_d = ZS_IDLE;
            end
        endcase

        cnt_en       = mem_we | mem_re;
        samp_valid_d = mem_re;
        samp_last_d  = mem_re & cnt_tc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ZS_IDLE;
            npass_q      <= '0;
            pass_idx_q   <= '0;
            conv_q       <= 1'b0;
            samp_valid_q <= 1'b0;
            samp_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            npass_q      <= npass_d;
            pass_idx_q   <= pass_idx_d;
            conv_q       <= conv_d;
            samp_valid_q <= samp_valid_d;
            samp_last_q  <= samp_last_d;
        end
    end

    assign samp_valid = samp_valid_q;
    assign samp_last  = samp_last_q;
    assign pass_idx   = pass_idx_q;

endmodule

// File: tb/tb_zbuf_sequencer.sv
// Directed bench for zbuf_sequencer: batch timing, zero-pass batch, random
// handshake pauses, early convergence, ignored start and mid-pass reset.
module tb_zbuf_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] num_passes;
    logic       in_valid;
    logic       in_ready;
    logic       stream_en;
    logic       converged;
    logic       mem_we;
    logic       mem_re;
    logic [6:0] mem_addr;
    logic       samp_valid;
    logic       samp_last;
    logic       pass_done;
    logic [7:0] pass_idx;
    logic       busy;
    logic       done;

    zbuf_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_passes (num_passes),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .stream_en  (stream_en),
        .converged  (converged),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .samp_valid (samp_valid),
        .samp_last  (samp_last),
        .pass_done  (pass_done),
        .pass_idx   (pass_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor state, sampled on the falling edge.
    int ncyc = 0;
    int start_cyc = 0;
    int wr_cnt, rd_cnt, exp_wr, exp_rd, done_cnt, done_cyc;
    int pd_q[$];
    bit prev_re = 1'b0;
    bit prev_last = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            prev_re   = 1'b0;
            prev_last = 1'b0;
        end else begin
            chk("samp_valid", int'(samp_valid), int'(prev_re));
            chk("samp_last", int'(samp_last), int'(prev_last));
            prev_re   = mem_re;
            prev_last = mem_re && (mem_addr == 7'd127);
            if (mem_we) begin
                chk("wr_addr", int'(mem_addr), exp_wr);
                exp_wr = (exp_wr + 1) % 128;
                wr_cnt++;
            end
            if (mem_re) begin
                chk("rd_addr", int'(mem_addr), exp_rd);
                exp_rd = (exp_rd + 1) % 128;
                rd_cnt++;
            end
            if (pass_done) pd_q.push_back(ncyc - start_cyc);
            if (done) begin
                done_cnt++;
                done_cyc = ncyc - start_cyc;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, int'(mem_we), 0);
        chk({tag, "_re"}, int'(mem_re), 0);
        chk({tag, "_ready"}, int'(in_ready), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_sv"}, int'(samp_valid), 0);
        chk({tag, "_sl"}, int'(samp_last), 0);
        chk({tag, "_pd"}, int'(pass_done), 0);
        chk({tag, "_pidx"}, int'(pass_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Run one batch; start is high in relative cycle 0.
    task automatic run_batch(input int np, input bit rnd, input int conv_read,
                             input bit glitch, input int abort_at);
        bit conv_sent = 1'b0;
        int rel;
        wr_cnt = 0; rd_cnt = 0; exp_wr = 0; exp_rd = 0;
        done_cnt = 0; done_cyc = -1;
        pd_q.delete();
        @(posedge clk); #1;
        start      = 1'b1;
        num_passes = 8'(np);
        start_cyc  = ncyc + 1;
        for (int k = 1; k < 3000; k++) begin
            @(posedge clk); #1;
            rel        = ncyc + 1 - start_cyc;
            start      = glitch && (rel == 50 || rel == 200);
            num_passes = 8'd5;
            in_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stream_en  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            converged  = 1'b0;
            if (conv_read >= 0 && !conv_sent && rd_cnt == conv_read) begin
                converged = 1'b1;
                conv_sent = 1'b1;
            end
            if (abort_at >= 0 && rel == abort_at) begin
                chk("abort_in_pass", int'(mem_re), 1);
                rst = 1'b1;
                #1;
                chk_all_zero("abort");
                start = 1'b0; in_valid = 1'b0; stream_en = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                chk("abort_pd_cnt", pd_q.size(), 0);
                chk("abort_done_cnt", done_cnt, 0);
                return;
            end
            if (done_cnt > 0) break;
        end
        start = 1'b0; in_valid = 1'b0; stream_en = 1'b0; converged = 1'b0;
        if (done_cnt == 0) chk("timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_passes = '0;
        in_valid = 1'b0; stream_en = 1'b0; converged = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Three passes, no pauses.
        run_batch(3, 1'b0, -1, 1'b0, -1);
        chk("p3_wr_cnt", wr_cnt, 128);
        chk("p3_rd_cnt", rd_cnt, 384);
        chk("p3_pd_cnt", pd_q.size(), 3);
        if (pd_q.size() == 3) begin
            chk("p3_pd0", pd_q[0], 257);
            chk("p3_pd1", pd_q[1], 386);
            chk("p3_pd2", pd_q[2], 515);
        end
        chk("p3_done_cyc", done_cyc, 516);
        chk("p3_done_cnt", done_cnt, 1);
        chk("p3_pidx", int'(pass_idx), 3);
        chk("p3_busy", int'(busy), 0);

        // Zero passes: load only.
        run_batch(0, 1'b0, -1, 1'b0, -1);
        chk("p0_wr_cnt", wr_cnt, 128);
        chk("p0_rd_cnt", rd_cnt, 0);
        chk("p0_pd_cnt", pd_q.size(), 0);
        chk("p0_done_cyc", done_cyc, 129);
        chk("p0_pidx", int'(pass_idx), 0);

        // Random in_valid / stream_en pauses.
        run_batch(2, 1'b1, -1, 1'b0, -1);
        chk("rnd_wr_cnt", wr_cnt, 128);
        chk("rnd_rd_cnt", rd_cnt, 256);
        chk("rnd_pd_cnt", pd_q.size(), 2);
        chk("rnd_pidx", int'(pass_idx), 2);

        // Convergence 40 reads into the second pass.
        run_batch(10, 1'b0, 168, 1'b0, -1);
        chk("cv_rd_cnt", rd_cnt, 256);
        chk("cv_pd_cnt", pd_q.size(), 2);
        chk("cv_done_cyc", done_cyc, 387);
        chk("cv_pidx", int'(pass_idx), 2);

        // start pulses during LOAD and PASS are ignored.
        run_batch(2, 1'b0, -1, 1'b1, -1);
        chk("gl_wr_cnt", wr_cnt, 128);
        chk("gl_rd_cnt", rd_cnt, 256);
        chk("gl_pd_cnt", pd_q.size(), 2);
        chk("gl_done_cyc", done_cyc, 387);
        chk("gl_pidx", int'(pass_idx), 2);

        // Reset mid-PASS, then a fresh single-pass batch.
        run_batch(3, 1'b0, -1, 1'b0, 200);
        chk("post_rst_busy", int'(busy), 0);
        run_batch(1, 1'b0, -1, 1'b0, -1);
        chk("rr_wr_cnt", wr_cnt, 128);
        chk("rr_rd_cnt", rd_cnt, 128);
        chk("rr_pd_cnt", pd_q.size(), 1);
        chk("rr_done_cyc", done_cyc, 258);
        chk("rr_pidx", int'(pass_idx), 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
